// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM over a BCD MM:SS.CC count
// advanced by a 100 Hz tick, with a lap freeze register and sticky overflow flag.
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       run,
  output logic       lap_hold,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

  localparam logic [7:0] MAX_MIN_BCD = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));

  state_t      state, state_n;
  logic        ss_prev, lap_prev;
  logic        press_ss, press_lap, counting;
  logic [7:0]  cs, sec, mn, cs_n, sec_n, mn_n;
  logic [23:0] lap_reg, lap_reg_n, disp_n;
  logic        ovf_n;

  // Two-digit BCD increment, 99 rolls to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] d);
    logic [7:0] r;
    if (d[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (d[7:4] == 4'd9) ? 4'd0 : d[7:4] + 4'd1;
    end else begin
      r = {d[7:4], d[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    press_ss  = btn_ss & ~ss_prev;
    // A simultaneous SS press swallows the LAP press.
    press_lap = btn_lap & ~lap_prev & ~press_ss;
    counting  = tick & ((state == S_RUN) | (state == S_LAP));

    state_n   = state;
    cs_n      = cs;
    sec_n     = sec;
    mn_n      = mn;
    ovf_n     = ovf;
    lap_reg_n = lap_reg;

    if (counting) begin
      if (cs == 8'h99) begin
        cs_n = 8'h00;
        if (sec == 8'h59) begin
          sec_n = 8'h00;
          if (mn == MAX_MIN_BCD) begin
            mn_n  = 8'h00;
            ovf_n = 1'b1;
          end else begin
            mn_n = bcd_inc(mn);
          end
        end else begin
          sec_n = bcd_inc(sec);
        end
      end else begin
        cs_n = bcd_inc(cs);
      end
    end

    case (state)
      S_IDLE: begin
        if (press_ss) state_n = S_RUN;
      end
      S_RUN: begin
        if (press_ss) begin
          state_n = S_PAUSE;
        end else if (press_lap) begin
          state_n   = S_LAP;
          lap_reg_n = {mn, sec, cs};
        end
      end
      S_LAP: begin
        if (press_ss)       state_n = S_PAUSE;
        else if (press_lap) state_n = S_RUN;
      end
      S_PAUSE: begin
        if (press_ss) begin
          state_n = S_RUN;
        end else if (press_lap) begin
          state_n = S_IDLE;
          cs_n    = 8'h00;
          sec_n   = 8'h00;
          mn_n    = 8'h00;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    disp_n = (state_n == S_LAP) ? lap_reg_n : {mn_n, sec_n, cs_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ss_prev  <= btn_ss;
      lap_prev <= btn_lap;
      cs       <= 8'h00;
      sec      <= 8'h00;
      mn       <= 8'h00;
      lap_reg  <= 24'h0;
      ovf      <= 1'b0;
      run      <= 1'b0;
      lap_hold <= 1'b0;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      cs_bcd   <= 8'h00;
    end else begin
      state    <= state_n;
      ss_prev  <= btn_ss;
      lap_prev <= btn_lap;
      cs       <= cs_n;
      sec      <= sec_n;
      mn       <= mn_n;
      lap_reg  <= lap_reg_n;
      ovf      <= ovf_n;
      run      <= (state_n == S_RUN) | (state_n == S_LAP);
      lap_hold <= (state_n == S_LAP);
      min_bcd  <= disp_n[23:16];
      sec_bcd  <= disp_n[15:8];
      cs_bcd   <= disp_n[7:0];
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random stimulus, checked
// against an integer-hundredths reference model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int MAXM = 1;
  localparam int FULL = (MAXM + 1) * 6000;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, btn_ss = 1'b0, btn_lap = 1'b0;
  logic run, lap_hold, ovf;
  logic [7:0] cs_bcd, sec_bcd, min_bcd;
  logic [26:0] dut_vec;

  int errors = 0, checks = 0;
  int m_state = IDLE, m_count = 0, m_lap = 0;
  bit m_ovf = 1'b0, m_ss_prev = 1'b0, m_lap_prev = 1'b0;

  stopwatch_ctrl #(.MAX_MIN(MAXM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .run(run), .lap_hold(lap_hold), .cs_bcd(cs_bcd), .sec_bcd(sec_bcd),
    .min_bcd(min_bcd), .ovf(ovf)
  );

  assign dut_vec = {run, lap_hold, ovf, min_bcd, sec_bcd, cs_bcd};

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Expected {run, lap_hold, ovf, MM, SS, CC}.
  function automatic logic [26:0] exp_vec();
    int v;
    v = (m_state == LAP) ? m_lap : m_count;
    return {(m_state == RUN || m_state == LAP), (m_state == LAP), m_ovf,
            bcd2(v / 6000), bcd2((v / 100) % 60), bcd2(v % 100)};
  endfunction

  task automatic model_update();
    bit pss, plap;
    int nc, ns;
    if (rst) begin
      m_state = IDLE; m_count = 0; m_lap = 0; m_ovf = 1'b0;
      m_ss_prev = btn_ss; m_lap_prev = btn_lap;
      return;
    end
    pss  = btn_ss && !m_ss_prev;
    plap = btn_lap && !m_lap_prev && !pss;
    nc = m_count;
    if (tick && (m_state == RUN || m_state == LAP)) begin
      nc = (m_count + 1) % FULL;
      if (nc == 0) m_ovf = 1'b1;
    end
    ns = m_state;
    if (pss) begin
      ns = (m_state == IDLE || m_state == PAUSE) ? RUN : PAUSE;
    end else if (plap) begin
      if (m_state == RUN) begin ns = LAP; m_lap = m_count; end
      else if (m_state == LAP) ns = RUN;
      else if (m_state == PAUSE) begin ns = IDLE; nc = 0; m_ovf = 1'b0; end
    end
    m_state = ns; m_count = nc;
    m_ss_prev = btn_ss; m_lap_prev = btn_lap;
  endtask

  task automatic step(input bit t, input bit s, input bit l);
    tick = t; btn_ss = s; btn_lap = l;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    rst = 1'b0;
    if (dut_vec !== 27'h0) begin
      errors++; $display("FAIL reset_state: got %h want %h", dut_vec, 27'h0);
    end
    checks++;
    step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle_tick: got %h want %h", dut_vec, exp_vec());
    end
    checks++;
  endtask

  task automatic test_basic_count();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_run: got %h want %h", dut_vec, exp_vec());
      end
      checks++;
    end
    step(1'b0, 1'b1, 1'b0);
    if (dut_vec !== {3'b000, 24'h000150}) begin
      errors++; $display("FAIL basic_stop: got %h want %h", dut_vec, {3'b000, 24'h000150});
    end
    checks++;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (dut_vec !== {3'b000, 24'h000150}) begin
        errors++; $display("FAIL pause_hold: got %h want %h", dut_vec, {3'b000, 24'h000150});
      end
      checks++;
    end
  endtask

  task automatic test_lap_flow();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== {3'b100, 24'h000200}) begin
      errors++; $display("FAIL lap_pre: got %h want %h", dut_vec, {3'b100, 24'h000200});
    end
    checks++;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (dut_vec !== {3'b110, 24'h000200}) begin
        errors++; $display("FAIL lap_frozen: got %h want %h", dut_vec, {3'b110, 24'h000200});
      end
      checks++;
    end
    step(1'b0, 1'b0, 1'b1);
    if (dut_vec !== {3'b100, 24'h000500}) begin
      errors++; $display("FAIL lap_release: got %h want %h", dut_vec, {3'b100, 24'h000500});
    end
    checks++;
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 233; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    if (dut_vec !== {3'b000, 24'h000733}) begin
      errors++; $display("FAIL clear_pause: got %h want %h", dut_vec, {3'b000, 24'h000733});
    end
    checks++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    if (dut_vec !== 27'h0) begin
      errors++; $display("FAIL clear_idle: got %h want %h", dut_vec, 27'h0);
    end
    checks++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== 27'h0) begin
      errors++; $display("FAIL idle_lap_ignored: got %h want %h", dut_vec, 27'h0);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== {3'b100, 24'h000009}) begin
      errors++; $display("FAIL simul_pre: got %h want %h", dut_vec, {3'b100, 24'h000009});
    end
    checks++;
    step(1'b1, 1'b1, 1'b1);
    if (dut_vec !== {3'b000, 24'h000010}) begin
      errors++; $display("FAIL simul_press: got %h want %h", dut_vec, {3'b000, 24'h000010});
    end
    checks++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FULL - 1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL wrap_run: got %h want %h", dut_vec, exp_vec());
      end
      checks++;
    end
    if (dut_vec !== {3'b100, 24'h015999}) begin
      errors++; $display("FAIL wrap_full: got %h want %h", dut_vec, {3'b100, 24'h015999});
    end
    checks++;
    step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== {3'b101, 24'h000000}) begin
      errors++; $display("FAIL wrap_ovf: got %h want %h", dut_vec, {3'b101, 24'h000000});
    end
    checks++;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== {3'b001, 24'h000000}) begin
      errors++; $display("FAIL ovf_sticky: got %h want %h", dut_vec, {3'b001, 24'h000000});
    end
    checks++;
    step(1'b0, 1'b0, 1'b1);
    if (dut_vec !== 27'h0) begin
      errors++; $display("FAIL ovf_clear: got %h want %h", dut_vec, 27'h0);
    end
    checks++;
  endtask

  task automatic test_reset_midrun();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FULL + 321; i++) step(1'b1, 1'b0, 1'b0);
    if (dut_vec !== {3'b101, 24'h000321}) begin
      errors++; $display("FAIL midrun_pre: got %h want %h", dut_vec, {3'b101, 24'h000321});
    end
    checks++;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    if (dut_vec !== 27'h0) begin
      errors++; $display("FAIL midrun_reset: got %h want %h", dut_vec, 27'h0);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (dut_vec !== 27'h0) begin
        errors++; $display("FAIL held_btn_no_start: got %h want %h", dut_vec, 27'h0);
      end
      checks++;
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    if (dut_vec !== {3'b100, 24'h000001}) begin
      errors++; $display("FAIL restart: got %h want %h", dut_vec, {3'b100, 24'h000001});
    end
    checks++;
  endtask

  task automatic test_random();
    bit s, l;
    s = btn_ss; l = btn_lap;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      if ($urandom_range(0, 7) == 0) l = ~l;
      rst = ($urandom_range(0, 299) == 0);
      step(1'($urandom_range(0, 2) != 0), s, l);
      rst = 1'b0;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_lap_flow();
    test_clear();
    test_simultaneous();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MAX_MIN, default 59, the highest minute value (0..99) before wrap.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 TICK  input  1  one-CLK-cycle pulse at 100 Hz (count enable).
REQ-005 BTN_SS  input  1  start/stop button level, already debounced and CLK-synchronous.
REQ-006 BTN_LAP  input  1  lap/clear button level, already debounced and CLK-synchronous.
REQ-007 RUN  output  1  high in states RUN and LAP.
REQ-008 LAP_HOLD  output  1  high in state LAP; display frozen.
REQ-009 CS_BCD  output  8  hundredths, two BCD digits, [7:4] tens.
REQ-010 SEC_BCD  output  8  seconds, two BCD digits, 00..59.
REQ-011 MIN_BCD  output  8  minutes, two BCD digits, 00..MAX_MIN.
REQ-012 OVF  output  1  sticky flag; set on full-scale wrap.

Function
REQ-013 The block SHALL register each button; press = BTN high now and low in the previous cycle; one press per rising edge regardless of hold time.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE and LAP.
REQ-015 Transitions on press SHALL be: IDLE+SS->RUN; RUN+SS->PAUSE; RUN+LAP->LAP; LAP+LAP->RUN; LAP+SS->PAUSE; PAUSE+SS->RUN; PAUSE+LAP->IDLE; IDLE+LAP ignored.
REQ-016 Presses of SS and LAP in the same cycle SHALL act as SS alone; the LAP press is discarded.
REQ-017 A press in cycle n SHALL change state at the end of cycle n; RUN and LAP_HOLD reflect it in cycle n+1.
REQ-018 The live count SHALL increment by 0.01 s on TICK only when the current registered state is RUN or LAP; this includes the cycle in which a press moves the FSM away from RUN or LAP.
REQ-019 BCD arithmetic rules: hundredths 99->00 carries into seconds; seconds 59->00 carries into minutes; each digit stays within 0..9.
REQ-020 At MAX_MIN:59.99, a counted TICK SHALL wrap to 00:00.00 and set OVF.
REQ-021 Entry to IDLE from PAUSE SHALL clear the live count to 00:00.00 and clear OVF on the same edge.
REQ-022 On RUN->LAP, the lap register SHALL load the live count as it stands in the press cycle, before any same-cycle TICK increment.
REQ-023 The outputs CS_BCD, SEC_BCD and MIN_BCD SHALL show the lap register while LAP_HOLD is high, otherwise the live count; all outputs are registered.
REQ-024 The live count SHALL continue counting during LAP; leaving LAP shows the live count from the next cycle.
REQ-025 PAUSE SHALL hold the count unchanged regardless of TICK.

Reset
REQ-026 When RST is high at a CLK edge: state=IDLE, live count and lap register=0, OVF=0, RUN=0, LAP_HOLD=0, outputs=00:00.00.
REQ-027 RST SHALL take priority over TICK and button presses in the same cycle.
REQ-028 During RST the button history registers SHALL load the current BTN levels, so a button held through reset release produces no press.

Verification
REQ-029 Basic count: reset; press SS; apply 150 TICKs; press SS -> RUN=0, display 00:01.50; 10 more TICKs leave it unchanged.
REQ-030 Lap flow: from RUN at 00:02.00 press LAP -> LAP_HOLD=1, display frozen at 00:02.00 while 300 TICKs pass; press LAP -> display 00:05.00, RUN=1.
REQ-031 Clear: in PAUSE at 00:07.33 press LAP -> IDLE, display 00:00.00, OVF=0; press LAP again in IDLE -> no state change.
REQ-032 Wrap: MAX_MIN=1; run to 01:59.99; one TICK -> 00:00.00 with OVF=1; OVF stays 1 through PAUSE and clears only on PAUSE->IDLE or RST.
REQ-033 Simultaneous events: SS and LAP pressed together in RUN with TICK high at 00:00.09 -> PAUSE (not LAP), count 00:00.10.
REQ-034 Reset mid-run: assert RST at 00:03.21 with TICK and BTN_SS high -> all zero, IDLE; BTN_SS held high after release -> no start until a new rising edge.
